// File: rtl/cplx_pkg.sv
// Shared types and constants for the complex multiplier datapath.
package cplx_pkg;

    // Issue-to-result depth of complex_multiplier (multiplier + adder stages).
    localparam int unsigned CPLX_MUL_LATENCY = 6;
    localparam int unsigned FP_W             = 32;

    // One complex sample: IEEE-754 single real and imaginary parts.
    typedef struct packed {
        logic [FP_W-1:0] re;
        logic [FP_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cplx_fifo.sv
// First-word-fall-through FIFO of complex samples with occupancy count.
module cplx_fifo
    import cplx_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  cplx_t         wr_data_i,
    input  logic          rd_en_i,
    output cplx_t         rd_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    cplx_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Gate the head with empty so the output reads zero when nothing is stored.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and count; a write to a full FIFO only lands if a pop frees the slot.
    always_comb begin
        do_rd    = rd_en_i && !empty_o;
        do_wr    = wr_en_i && (!full_o || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/complex_result_buffer.sv
// Captures complex_multiplier results into a ready/valid FIFO, with credit-based issue throttling.
module complex_result_buffer
    import cplx_pkg::*;
#(
    parameter int unsigned LATENCY = CPLX_MUL_LATENCY,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [FP_W-1:0] res_real,
    input  logic [FP_W-1:0] res_imag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_real,
    output logic [FP_W-1:0] out_imag,
    output logic [AW:0]     occupancy,
    output logic            err_ovf
);

    logic [LATENCY-1:0] vline_q, vline_d;
    logic [AW:0]        reserved_q, reserved_d;
    logic               err_ovf_q, err_ovf_d;
    logic               accept, pop, wr_en;
    logic               fifo_full, fifo_empty;
    cplx_t              head;

    // Credits cover both stored and in-flight results, so a landing result always has a slot.
    assign issue_ready = (reserved_q < (AW+1)'(DEPTH));
    assign accept      = issue_valid && issue_ready;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign wr_en       = vline_q[LATENCY-1];
    assign out_real    = head.re;
    assign out_imag    = head.im;
    assign err_ovf     = err_ovf_q;

    // Next-state for the valid line, the credit counter and the sticky overflow flag.
    always_comb begin
        // Truncating the concatenation shifts in the accept bit and also covers LATENCY == 1.
        vline_d    = LATENCY'({vline_q, accept});
        reserved_d = reserved_q;
        case ({accept, pop})
            2'b10:   reserved_d = reserved_q + (AW+1)'(1);
            2'b01:   reserved_d = reserved_q - (AW+1)'(1);
            default: reserved_d = reserved_q;
        endcase
        err_ovf_d = err_ovf_q || (wr_en && fifo_full && !pop);
    end

    // State registers with synchronous active-low reset; clearing vline discards in-flight results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vline_q    <= '0;
            reserved_q <= '0;
            err_ovf_q  <= 1'b0;
        end else begin
            vline_q    <= vline_d;
            reserved_q <= reserved_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    cplx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wr_en),
        .wr_data_i ({res_real, res_imag}),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (occupancy),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule

// File: tb/tb_complex_result_buffer.sv
// Self-checking bench for complex_result_buffer: table vectors, directed sequences, random vs. model.
module tb_complex_result_buffer;

    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_ready;
    logic [31:0]   res_real, res_imag;
    logic          out_valid, out_ready;
    logic [31:0]   out_real, out_imag;
    logic [AW:0]   occupancy;
    logic          err_ovf;

    always #5 clk = ~clk;

    complex_result_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .res_real    (res_real),
        .res_imag    (res_imag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .occupancy   (occupancy),
        .err_ovf     (err_ovf)
    );

    // Reference model: issues in flight (with the cycle their result appears) and stored results.
    typedef struct {
        int          due;
        logic [63:0] data;
    } flight_t;

    flight_t     iq[$];
    logic [63:0] fq[$];
    logic        m_ovf;
    int          cyc;
    int          n_checks, n_fail;

    // Values sampled in the most recent tick.
    logic        s_ready, s_valid, s_ovf;
    logic [31:0] s_re, s_im;
    logic [AW:0] s_occ;

    typedef struct {
        logic     iv;
        logic     ordy;
        logic     exp_ready;
        logic     exp_valid;
        int       exp_occ;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model, then advance the model.
    task automatic tick(input logic iv, input logic ordy, input logic [63:0] data);
        logic        exp_ready, exp_valid, acc, pop, wr;
        logic [63:0] head, wdata;
        issue_valid = iv;
        out_ready   = ordy;
        if (iq.size() > 0 && iq[0].due == cyc) {res_real, res_imag} = iq[0].data;
        else {res_real, res_imag} = {$urandom, $urandom};
        @(negedge clk);
        s_ready = issue_ready;
        s_valid = out_valid;
        s_re    = out_real;
        s_im    = out_imag;
        s_occ   = occupancy;
        s_ovf   = err_ovf;
        exp_ready = (fq.size() + iq.size()) < DEPTH;
        exp_valid = fq.size() != 0;
        head      = exp_valid ? fq[0] : 64'd0;
        check("issue_ready", s_ready, exp_ready);
        check("out_valid", s_valid, exp_valid);
        check("out_data", {s_re, s_im}, head);
        check("occupancy", s_occ, fq.size());
        check("err_ovf", s_ovf, m_ovf);
        acc = iv && exp_ready;
        pop = exp_valid && ordy;
        wr  = iq.size() > 0 && iq[0].due == cyc;
        wdata = wr ? iq[0].data : 64'd0;
        @(posedge clk);
        #1;
        if (wr) void'(iq.pop_front());
        if (pop) void'(fq.pop_front());
        if (wr) begin
            if (fq.size() == DEPTH) m_ovf = 1'b1;
            else fq.push_back(wdata);
        end
        if (acc) iq.push_back('{due: cyc + LAT, data: data});
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        issue_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        iq.delete();
        fq.delete();
        m_ovf = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, accepts, start, tag, exp_tag;
        logic [31:0] got_re[$];
        int          got_cyc[$];
        logic        prev_valid, prev_ordy, dropped;
        logic [31:0] prev_re, prev_im;

        n_checks = 0; n_fail = 0; cyc = 0; m_ovf = 1'b0;
        rst = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
        res_real = '0; res_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset then idle.
        tick(1'b0, 1'b0, 64'd0);
        check("rst_issue_ready", s_ready, 1);
        check("rst_out_valid", s_valid, 0);
        check("rst_occupancy", s_occ, 0);
        check("rst_out_real", s_re, 0);

        // Single issue at cycle 10; result must be visible from cycle 17.
        while (cyc < 10) tick(1'b0, 1'b1, 64'd0);
        tick(1'b1, 1'b1, {32'h3F800000, 32'h40000000});
        rise = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 64'd0);
            if (s_valid && rise < 0) begin
                rise = cyc - 1;
                check("single_data", {s_re, s_im}, {32'h3F800000, 32'h40000000});
            end
        end
        check("single_rise_cycle", rise, 17);
        check("single_occ_after", s_occ, 0);

        // Credit throttle: table of expected ready/valid/occupancy with consumer stalled.
        for (int k = 0; k < 16; k++) begin
            tbl[k].iv        = 1'b1;
            tbl[k].ordy      = 1'b0;
            tbl[k].exp_ready = (k < DEPTH);
            tbl[k].exp_occ   = (k < LAT + 1) ? 0 : ((k - LAT > DEPTH) ? DEPTH : k - LAT);
            tbl[k].exp_valid = (tbl[k].exp_occ != 0);
        end
        accepts = 0;
        for (int k = 0; k < 16; k++) begin
            tick(tbl[k].iv, tbl[k].ordy, {32'(k + 1), 32'(~k)});
            check("tbl_issue_ready", s_ready, tbl[k].exp_ready);
            check("tbl_out_valid", s_valid, tbl[k].exp_valid);
            check("tbl_occupancy", s_occ, tbl[k].exp_occ);
            if (s_ready) accepts++;
        end
        check("throttle_accepts", accepts, 8);
        check("throttle_ovf", s_ovf, 0);
        tick(1'b0, 1'b1, 64'd0);
        check("throttle_ready_at_pop", s_ready, 0);
        tick(1'b0, 1'b0, 64'd0);
        check("throttle_ready_after_pop", s_ready, 1);
        repeat (10) tick(1'b0, 1'b1, 64'd0);

        // Streaming: 20 back-to-back issues, consumer always ready.
        start = cyc;
        dropped = 1'b0;
        for (int n = 0; n < 36; n++) begin
            tick(n < 20, 1'b1, {32'(n + 1), 32'(3 * n)});
            if (n < 20 && !s_ready) dropped = 1'b1;
            if (s_valid) begin
                got_re.push_back(s_re);
                got_cyc.push_back(cyc - 1);
            end
        end
        check("stream_ready_held", dropped, 0);
        check("stream_count", got_re.size(), 20);
        if (got_re.size() == 20) begin
            check("stream_first_cycle", got_cyc[0], start + LAT + 1);
            check("stream_no_bubbles", got_cyc[19], got_cyc[0] + 19);
            for (int i = 0; i < 20; i++) check("stream_order", got_re[i], i + 1);
        end

        // Backpressure: out_ready toggles 1010..., head held while stalled, order preserved.
        tag = 100; exp_tag = 100;
        prev_valid = 1'b0; prev_ordy = 1'b1; prev_re = '0; prev_im = '0;
        for (int n = 0; n < 60; n++) begin
            logic iv, ordy;
            iv   = (n < 24);
            ordy = (n % 2 == 0);
            tick(iv, ordy, {32'(tag), 32'(tag ^ 32'h5A5A)});
            if (iv && s_ready) tag++;
            if (prev_valid && !prev_ordy) begin
                check("bp_head_stable", {s_re, s_im}, {prev_re, prev_im});
            end
            if (s_valid && ordy) begin
                check("bp_order", s_re, exp_tag);
                exp_tag++;
            end
            prev_valid = s_valid; prev_ordy = ordy; prev_re = s_re; prev_im = s_im;
        end
        check("bp_all_drained", exp_tag, tag);

        // Reset mid-operation: 4 stored, 3 in flight.
        for (int k = 0; k < 10; k++) tick(k < 7, 1'b0, {32'(200 + k), 32'(k)});
        check("mid_occ_before", s_occ, 3);
        do_reset();
        tick(1'b0, 1'b0, 64'd0);
        check("mid_rst_occ", s_occ, 0);
        check("mid_rst_valid", s_valid, 0);
        check("mid_rst_ready", s_ready, 1);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 64'd0);
            check("mid_rst_occ_stays", s_occ, 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, {$urandom, $urandom});
        end
        repeat (20) tick(1'b0, 1'b1, 64'd0);
        check("final_occ", s_occ, 0);
        check("final_ovf", s_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/complex_result_buffer.md
Name: complex_result_buffer

Overview:
Downstream stage of complex_multiplier. The multiplier pipeline cannot stall, so this block tracks in-flight operand issues with a valid shift line and captures each xy_real/xy_imag pair on the cycle it emerges. It queues results in a FIFO with a ready/valid consumer interface, and throttles upstream issue with a credit check so no result is ever dropped.

Parameters:
LATENCY, 6, cycles from operand issue to result on res_real/res_imag (multiplier + adder depth); must be >= 1
DEPTH, 8, FIFO entries (power of two, >= 2)
AW, 3, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
issue_valid  in  1  upstream presents operands to complex_multiplier this cycle
issue_ready  out  1  upstream may issue; an issue counts only when issue_valid && issue_ready
res_real  in  32  xy_real from complex_multiplier
res_imag  in  32  xy_imag from complex_multiplier
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_real  out  32  head real part (IEEE-754 single)
out_imag  out  32  head imaginary part
occupancy  out  AW+1  entries currently stored in the FIFO (0..DEPTH)
err_ovf  out  1  sticky: result arrived while the FIFO was full

Behaviour:
- Reset (rst==0 at a clk edge): valid line cleared, FIFO pointers and count 0, credit counter 0, err_ovf 0. Results already in the multiplier are discarded.
- Outputs after reset: out_valid=0, out_real=out_imag=0, occupancy=0, err_ovf=0, issue_ready=1.
- Issue accept at cycle t: vline[0] is set at the end of cycle t. Each cycle vline[k] <= vline[k-1].
- The result of the cycle-t issue is valid on res_* during cycle t+LATENCY, when vline[LATENCY-1]==1. It is written to the FIFO at the end of that cycle.
- out_valid rises in cycle t+LATENCY+1 at the earliest; there is no bypass path.
- Credit counter `reserved` = FIFO count + in-flight issues.
  - Increments on an accepted issue.
  - Decrements on a pop (out_valid && out_ready).
  - Accept and pop in the same cycle: unchanged.
- issue_ready = (reserved < DEPTH), decoded combinationally from registered state. There is no combinational path from issue_valid or out_ready to issue_ready.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0); out_real/out_imag = mem[rd_ptr] when valid, else 0.
  - Pop on out_valid && out_ready.
  - Write on vline[LATENCY-1].
  - Write and pop in the same cycle, including at count==DEPTH: both occur and count is unchanged.
- Pointers are AW bits and wrap modulo DEPTH. Count is AW+1 bits.
- Full write (count==DEPTH with no pop): data dropped, count unchanged, err_ovf set and held until reset. Unreachable when the credit rule is respected; this is a verification check only.
- out_valid && !out_ready: head data must remain stable.
- Back-to-back issue sustains 1 result/cycle while the consumer holds out_ready=1.

Decomposition:
- Shared package cplx_pkg:
  - CPLX_MUL_LATENCY constant (6), which drives LATENCY at instantiation.
  - FP_W=32.
  - Typedef cplx_t (packed {real, imag}, 64 bits).
- One sub-module, cplx_fifo:
  - DEPTH x 64 FWFT storage, rd/wr pointers, count, full/empty flags.
- Valid line, credit counter and err_ovf live in complex_result_buffer.

Test Plan:
- Reset then idle: check issue_ready=1, out_valid=0, occupancy=0, out_real=0.
- Single issue:
  - Stimulus: issue at cycle 10; drive res_real=32'h3F800000, res_imag=32'h40000000 in cycle 16; out_ready=1.
  - Required: out_valid rises in cycle 17 with those values; popped that cycle; occupancy back to 0.
- Credit throttle:
  - Stimulus: out_ready=0, issue_valid=1 continuously.
  - Required: exactly 8 issues accepted; issue_ready=0 from the cycle after the 8th accept. After results land: occupancy=8 and err_ovf=0.
  - Then out_ready=1 for 1 cycle: issue_ready=1 on the next cycle.
- Streaming:
  - Stimulus: 20 back-to-back issues with incrementing res_real (1..20); out_ready=1.
  - Required: 20 outputs in order, one per cycle, no bubbles after the first; issue_ready never drops.
- Backpressure stability: toggle out_ready 1010...; verify head data is stable while out_ready=0 and order is preserved.
- Reset mid-operation:
  - Stimulus: 4 results stored, 3 in flight; assert rst=0 for 1 cycle.
  - Required: occupancy=0, out_valid=0, issue_ready=1. In-flight results arriving after reset are not written; occupancy stays 0.
